ram8_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one `ram8` storage block (8 words × 16 bits; combinational read via `out`, clocked write when `load`=1) between two requesters, e.g. the CPU data port and a loader/DMA port. It sits directly in front of `ram8`. It accepts level-held requests and serializes them into single-cycle RAM accesses. It returns a one-cycle acknowledge with read data.

---
 rtl/ram8_ctrl_pkg.sv | 15 +
 rtl/ram8_arbiter_rr_pick2.sv | 22 ++
 rtl/ram8_arbiter.sv | 124 ++++++++++++
 tb/tb_ram8_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ram8_ctrl_pkg.sv
// Shared types and default widths for the ram8 two-port arbiter.
package ram8_ctrl_pkg;

  localparam int unsigned DEF_ADR_W  = 3;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/ram8_arbiter_rr_pick2.sv
// Two-input round-robin picker: a lone request wins, a tie goes to prio.
module rr_pick2
  import ram8_ctrl_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t prio,
  output logic     gnt_valid,
  output port_id_t gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      gnt_id = prio;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Serializes two level-held request ports into single-cycle ram8 accesses
// (IDLE -> SERVE -> RESP) with strict alternation under contention.
module ram8_arbiter
  import ram8_ctrl_pkg::*;
#(
  parameter int unsigned ADR_W  = DEF_ADR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADR_W-1:0]  adr0,
  input  logic [ADR_W-1:0]  adr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADR_W-1:0]  ram_adr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  arb_state_t        state_q, state_d;
  port_id_t          prio_q, prio_d;
  port_id_t          gnt_id_q, gnt_id_d;
  logic [ADR_W-1:0]  ram_adr_q, ram_adr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_load_q, ram_load_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic     pick_valid;
  port_id_t pick_id;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .prio      (prio_q),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      gnt_id_q   <= 1'b0;
      ram_adr_q  <= '0;
      ram_data_q <= '0;
      ram_load_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      gnt_id_q   <= gnt_id_d;
      ram_adr_q  <= ram_adr_d;
      ram_data_q <= ram_data_d;
      ram_load_q <= ram_load_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // ram_load_q doubles as the latched write flag while in SERVE.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gnt_id_d   = gnt_id_q;
    ram_adr_d  = ram_adr_q;
    ram_data_d = ram_data_q;
    ram_load_d = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = SERVE;
          gnt_id_d   = pick_id;
          ram_load_d = pick_id ? we1 : we0;
          ram_adr_d  = pick_id ? adr1 : adr0;
          ram_data_d = pick_id ? wdata1 : wdata0;
        end
      end
      SERVE: begin
        state_d = RESP;
        if (!ram_load_q) begin
          if (gnt_id_q) rdata1_d = ram_out;
          else          rdata0_d = ram_out;
        end
        ack0_d = ~gnt_id_q;
        ack1_d = gnt_id_q;
      end
      RESP: begin
        state_d = IDLE;
        prio_d  = ~gnt_id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ram_adr  = ram_adr_q;
  assign ram_data = ram_data_q;
  assign ram_load = ram_load_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with a behavioural ram8 attached.
module tb_ram8_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [2:0]  adr0, adr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [2:0]  ram_adr;
  logic [15:0] ram_data;
  logic        ram_load;
  logic [15:0] ram_out;

  logic [15:0] mem [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_load) mem[ram_adr] <= ram_data;
  assign ram_out = mem[ram_adr];

  ram8_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_adr(ram_adr), .ram_data(ram_data), .ram_load(ram_load),
    .ram_out(ram_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Caller is at a negedge with the FSM in IDLE; covers SERVE, RESP and return to IDLE.
  task automatic xfer(input bit port, input bit we, input logic [2:0] adr,
                      input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
    if (port) begin req1 = 1'b1; we1 = we; adr1 = adr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; adr0 = adr; wdata0 = wd; end
    step();
    chk({tag, "_serve_load"}, 32'(ram_load), 32'(we));
    chk({tag, "_serve_adr"}, 32'(ram_adr), 32'(adr));
    if (we) chk({tag, "_serve_data"}, 32'(ram_data), 32'(wd));
    chk({tag, "_serve_noack"}, 32'({ack1, ack0}), 32'(0));
    if (port) req1 = 1'b0; else req0 = 1'b0;
    step();
    chk({tag, "_resp_load"}, 32'(ram_load), 32'(0));
    chk({tag, "_resp_ack"}, 32'({ack1, ack0}), port ? 32'(2) : 32'(1));
    if (!we) chk({tag, "_rdata"}, 32'(port ? rdata1 : rdata0), 32'(exp_rd));
    step();
    chk({tag, "_idle_ack"}, 32'({ack1, ack0}), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    adr0 = 3'd5; adr1 = 3'd6; wdata0 = 16'hFFFF; wdata1 = 16'hEEEE;

    // Reset held with both requests active
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ack", 32'({ack1, ack0}), 32'(0));
      chk("rst_load", 32'(ram_load), 32'(0));
      chk("rst_adr", 32'(ram_adr), 32'(0));
      chk("rst_data", 32'(ram_data), 32'(0));
      chk("rst_rdata", 32'({rdata1, rdata0}), 32'(0));
    end
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", 32'({ram_load, ack1, ack0}), 32'(0));

    // Port 0 write then read back
    xfer(1'b0, 1'b1, 3'd0, 16'h1234, 16'h0, "p0_wr");
    chk("mem0", 32'(mem[0]), 32'h1234);
    xfer(1'b0, 1'b0, 3'd0, 16'h0, 16'h1234, "p0_rd");

    // Fresh reset so prio is 0 again, then contention
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    req0 = 1'b1; we0 = 1'b1; adr0 = 3'd1; wdata0 = 16'h5678;
    req1 = 1'b1; we1 = 1'b0; adr1 = 3'd1; wdata1 = 16'h0;
    step();
    chk("cont_p0_load", 32'(ram_load), 32'(1));
    chk("cont_p0_adr", 32'(ram_adr), 32'(1));
    chk("cont_p0_data", 32'(ram_data), 32'h5678);
    req0 = 1'b0;
    step();
    chk("cont_ack0", 32'({ack1, ack0}), 32'(1));
    step();
    chk("cont_gap_idle", 32'({ack1, ack0}), 32'(0));
    step();
    chk("cont_p1_load", 32'(ram_load), 32'(0));
    chk("cont_p1_adr", 32'(ram_adr), 32'(1));
    req1 = 1'b0;
    step();
    chk("cont_ack1", 32'({ack1, ack0}), 32'(2));
    chk("cont_rdata1", 32'(rdata1), 32'h5678);
    step();

    // Fairness: both held for 12 cycles, prio is 0 here
    req0 = 1'b1; we0 = 1'b0; adr0 = 3'd0;
    req1 = 1'b1; we1 = 1'b0; adr1 = 3'd1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("fair_ack0", 32'(ack0), 32'((i % 3 == 1) && ((i / 3) % 2 == 0)));
      chk("fair_ack1", 32'(ack1), 32'((i % 3 == 1) && ((i / 3) % 2 == 1)));
      if (i == 11) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("fair_rdata0", 32'(rdata0), 32'h1234);
    chk("fair_rdata1", 32'(rdata1), 32'h5678);

    // Field change after grant: adr1 flips to 3 during SERVE
    xfer(1'b1, 1'b1, 3'd2, 16'h00AA, 16'h0, "p1_wr2");
    xfer(1'b0, 1'b1, 3'd3, 16'hBEEF, 16'h0, "p0_wr3");
    req1 = 1'b1; we1 = 1'b0; adr1 = 3'd2;
    step();
    adr1 = 3'd3;
    chk("fc_serve_adr", 32'(ram_adr), 32'(2));
    step();
    adr1 = 3'd3;
    chk("fc_ack1", 32'({ack1, ack0}), 32'(2));
    chk("fc_rdata1", 32'(rdata1), 32'h00AA);
    req1 = 1'b0;
    step();

    // Reset during a write SERVE
    req0 = 1'b1; we0 = 1'b1; adr0 = 3'd4; wdata0 = 16'h9999;
    step();
    chk("mid_serve_load", 32'(ram_load), 32'(1));
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_load_async", 32'(ram_load), 32'(0));
    chk("mid_rst_adr", 32'(ram_adr), 32'(0));
    req0 = 1'b0;
    step();
    chk("mid_rst_noack", 32'({ack1, ack0}), 32'(0));
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'({ram_load, ack1, ack0}), 32'(0));
    xfer(1'b1, 1'b0, 3'd0, 16'h0, 16'h1234, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
